// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and bus width shared by the GPIO controller
package gpio_pkg;
    localparam int GPIO_DATA_W = 32;
    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_DIR     = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_STATUS  = 3'd5;
    localparam logic [2:0] GPIO_OUT_SET = 3'd6;
    localparam logic [2:0] GPIO_OUT_CLR = 3'd7;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-pin input synchroniser, previous-value flop and edge flags
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // shift the pad through the synchroniser, then remember the last synced level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, read-back, set/clear and edge interrupts
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NPINS       = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             IOAdr,
    input  logic                   WriteIO,
    input  logic [GPIO_DATA_W-1:0] IOWrite,
    input  logic                   ReadIO,
    output logic [GPIO_DATA_W-1:0] IORead,
    output logic                   irq,
    inout  wire  [NPINS-1:0]       gpio_pins
);
    logic [NPINS-1:0]       r_out, r_dir, r_rise_en, r_fall_en, r_status;
    logic [GPIO_DATA_W-1:0] r_rdata;
    logic                   r_irq;
    logic [NPINS-1:0]       w_wdata, w_in, w_rise, w_fall, w_evt, w_w1c, w_rsel;
    logic [GPIO_DATA_W-1:0] w_rdata;
    logic                   w_unused;

    assign w_wdata  = IOWrite[NPINS-1:0];
    assign w_unused = ^IOWrite;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        assign gpio_pins[i] = r_dir[i] ? r_out[i] : 1'bz;
        gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .i_pin  (gpio_pins[i]),
            .o_sync (w_in[i]),
            .o_rise (w_rise[i]),
            .o_fall (w_fall[i])
        );
    end

    assign w_evt = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_w1c = (WriteIO && IOAdr == GPIO_STATUS) ? w_wdata : '0;

    // control registers; OUT also takes atomic set/clear, IN writes fall through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (WriteIO) begin
            r_out     <= IOAdr == GPIO_OUT     ? w_wdata :
                         IOAdr == GPIO_OUT_SET ? r_out | w_wdata :
                         IOAdr == GPIO_OUT_CLR ? r_out & ~w_wdata : r_out;
            r_dir     <= IOAdr == GPIO_DIR     ? w_wdata : r_dir;
            r_rise_en <= IOAdr == GPIO_RISE_EN ? w_wdata : r_rise_en;
            r_fall_en <= IOAdr == GPIO_FALL_EN ? w_wdata : r_fall_en;
        end
    end

    // sticky status: W1C is applied first so a coincident edge keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_evt;
            r_irq    <= |r_status;
        end
    end

    // read mux; write-only and unmapped bits read as zero
    always_comb begin
        w_rsel = IOAdr == GPIO_OUT     ? r_out     :
                 IOAdr == GPIO_DIR     ? r_dir     :
                 IOAdr == GPIO_IN      ? w_in      :
                 IOAdr == GPIO_RISE_EN ? r_rise_en :
                 IOAdr == GPIO_FALL_EN ? r_fall_en :
                 IOAdr == GPIO_STATUS  ? r_status  : '0;
        w_rdata = '0;
        w_rdata[NPINS-1:0] = w_rsel;
    end

    // read data is captured on a read strobe and held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdata <= '0;
        else if (ReadIO) r_rdata <= w_rdata;
    end

    assign IORead = r_rdata;
    assign irq    = r_irq;
endmodule
